// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int               BYTE_W      = 8;
  localparam logic [BYTE_W-1:0] EOP_DEFAULT = 8'h0A;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin first-set search: the first asserted request after prev, with wrap.
module rr_pick #(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   prev,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk prev+1, prev+2, ... (mod NUM_SRC). prev itself is visited last.
  always_comb begin
    idx   = prev;
    found = 1'b0;
    cand  = prev;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (cand == IDX_W'(NUM_SRC - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter in front of the usb_uart input byte slot.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int                NUM_SRC      = 4,
  parameter  int                MAX_BURST    = 64,
  parameter  logic [BYTE_W-1:0] EOP_BYTE     = EOP_DEFAULT,
  parameter  int                IDLE_TIMEOUT = 255,
  localparam int                IDX_W        = $clog2(NUM_SRC)
) (
  input  logic                            clk_48mhz,
  input  logic                            reset_n,
  input  logic [NUM_SRC-1:0][BYTE_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic [BYTE_W-1:0]               uart_in_data,
  output logic                            uart_in_valid,
  input  logic                            uart_in_ready,
  output logic [IDX_W-1:0]                grant_id,
  output logic                            busy
);

  // Compare against count-before-increment, so "last" is limit-1.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_d, pick_idx;
  logic [7:0]        burst_q, burst_d, idle_q, idle_d;
  logic              any_req, slot_free, accept;
  logic [BYTE_W-1:0] cur_byte;

  assign slot_free = !uart_in_valid || uart_in_ready;
  assign cur_byte  = src_data[grant_id];
  assign busy      = (state_q == BUSY);
  assign accept    = busy && src_valid[grant_id] && slot_free;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (src_valid),
    .prev    (grant_id),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Only the owner sees ready, and only when the slot can take a byte.
  always_comb begin
    src_ready = '0;
    if (busy) src_ready[grant_id] = slot_free;
  end

  // Next-state: arbitrate in IDLE, count bytes/stalls and decide release in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_idx;
          burst_d = '0;
          idle_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
          idle_d  = '0;
          if (cur_byte == EOP_BYTE || burst_q == BURST_LAST) state_d = IDLE;
        end else if (!src_valid[grant_id]) begin
          // Backpressure with valid high is not a stall, so only count here.
          idle_d = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
          if (idle_q == IDLE_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state, owner and counters. grant_id keeps the last owner on release.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_id <= IDX_W'(NUM_SRC - 1);
      burst_q  <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
    end
  end

  // Single-entry output slot; it may drain after release while a new owner is picked.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      uart_in_valid <= 1'b0;
      uart_in_data  <= '0;
    end else if (accept) begin
      uart_in_valid <= 1'b1;
      uart_in_data  <= cur_byte;
    end else if (uart_in_ready) begin
      uart_in_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter with a transaction-level reference model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int         N   = 4;
  localparam int         MB  = 4;
  localparam int         TO  = 5;
  localparam logic [7:0] EOP = 8'h0A;

  logic                 clk_48mhz = 1'b0;
  logic                 reset_n   = 1'b1;
  logic [N-1:0][7:0]    src_data;
  logic [N-1:0]         src_valid;
  logic [N-1:0]         src_ready;
  logic [7:0]           uart_in_data;
  logic                 uart_in_valid;
  logic                 uart_in_ready;
  logic [1:0]           grant_id;
  logic                 busy;

  uart_tx_arbiter #(
    .NUM_SRC(N), .MAX_BURST(MB), .EOP_BYTE(EOP), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .uart_in_data  (uart_in_data),
    .uart_in_valid (uart_in_valid),
    .uart_in_ready (uart_in_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int n_chk = 0;
  int n_err = 0;

  // Per-source byte queues and driving knobs.
  byte unsigned q[N][$];
  int           pv[N];
  int           rdy_pct;

  // Reference model: owner, whether a grant is held, bytes sent and stall run in this grant,
  // and the contents of the output slot.
  int           m_own;
  bit           m_held;
  int           m_sent;
  int           m_stall;
  bit           m_sv;
  byte unsigned m_sd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  task automatic m_reset();
    m_own = N - 1; m_held = 0; m_sent = 0; m_stall = 0; m_sv = 0; m_sd = 8'h00;
  endtask

  // One clock: drive at negedge, check ready, advance the model, check registered outputs.
  task automatic cycle();
    logic [N-1:0] rdy_s, exp_rdy;
    bit           fr, acc;
    byte unsigned b;
    @(negedge clk_48mhz);
    for (int i = 0; i < N; i++) begin
      src_valid[i] = (q[i].size() > 0) && ($urandom_range(99) < pv[i]);
      src_data[i]  = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
    uart_in_ready = ($urandom_range(99) < rdy_pct);
    #1;
    fr      = !m_sv || uart_in_ready;
    exp_rdy = '0;
    if (m_held && fr) exp_rdy[m_own] = 1'b1;
    rdy_s = src_ready;
    chk("src_ready", 32'(rdy_s), 32'(exp_rdy));
    acc = 0;
    b   = 8'h00;
    if (!m_held) begin
      if (src_valid != '0) begin
        m_own = rr_next(m_own, src_valid);
        m_held = 1; m_sent = 0; m_stall = 0;
      end
    end else if (src_valid[m_own] && fr) begin
      acc = 1; b = src_data[m_own];
      m_sent++; m_stall = 0;
      if (b == EOP || m_sent == MB) m_held = 0;
    end else if (!src_valid[m_own]) begin
      m_stall++;
      if (m_stall == TO) m_held = 0;
    end
    if (acc) begin m_sv = 1; m_sd = b; end
    else if (uart_in_ready) m_sv = 0;
    @(posedge clk_48mhz);
    #1;
    for (int i = 0; i < N; i++)
      if (src_valid[i] && rdy_s[i]) void'(q[i].pop_front());
    chk("uart_in_valid", 32'(uart_in_valid), 32'(m_sv));
    chk("uart_in_data",  32'(uart_in_data),  32'(m_sd));
    chk("busy",          32'(busy),          32'(m_held));
    chk("grant_id",      32'(grant_id),      32'(m_own));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic drain(input int limit);
    int k = 0;
    while (!(all_empty() && !m_held && !m_sv) && k < limit) begin
      cycle();
      k++;
    end
    chk("drain_in_time", 32'(k < limit), 32'(1));
  endtask

  task automatic push_pkt(input int s, input int len, input bit with_eop);
    byte unsigned b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(255));
      if (b == EOP) b = 8'h0B;
      q[s].push_back(b);
    end
    if (with_eop) q[s].push_back(EOP);
  endtask

  initial begin
    bit found;
    src_valid = '0; src_data = '0; uart_in_ready = 1'b0;
    rdy_pct = 100;
    for (int i = 0; i < N; i++) pv[i] = 100;
    m_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #1;
    chk("rst_valid",    32'(uart_in_valid), 32'(0));
    chk("rst_data",     32'(uart_in_data),  32'(0));
    chk("rst_src_rdy",  32'(src_ready),     32'(0));
    chk("rst_grant_id", 32'(grant_id),      32'(N - 1));
    chk("rst_busy",     32'(busy),          32'(0));
    @(negedge clk_48mhz);
    reset_n = 1'b1;

    // Single source, one packet.
    q[0] = '{8'h41, 8'h42, 8'h0A};
    drain(20);
    chk("single_owner", 32'(grant_id), 32'(0));

    // Contention between src1 and src3.
    q[1] = '{8'h58, 8'h0A};
    q[3] = '{8'h58, 8'h0A};
    drain(30);

    // Burst limit with src0 pending behind a long src2 stream.
    for (int k = 0; k < 10; k++) q[2].push_back(8'(8'h20 + k));
    repeat (2) cycle();
    q[0] = '{8'h30, 8'h31, 8'h0A};
    drain(80);

    // Backpressure mid-packet: no stall timeout, no loss.
    q[1] = '{8'h61, 8'h62, 8'h0A};
    repeat (2) cycle();
    rdy_pct = 0;
    repeat (20) cycle();
    rdy_pct = 100;
    drain(30);

    // Timeout: src0 sends one byte then goes quiet; src1 waits.
    q[0] = '{8'h11};
    repeat (3) cycle();
    q[1] = '{8'h22, 8'h0A};
    drain(40);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        for (int i = 0; i < N; i++) pv[i] = int'($urandom_range(30, 100));
        rdy_pct = int'($urandom_range(40, 100));
      end
      if ($urandom_range(99) < 8) begin
        int s = int'($urandom_range(N - 1));
        if (q[s].size() < 20) push_pkt(s, int'($urandom_range(0, 6)), ($urandom_range(99) < 70));
      end
      cycle();
    end
    for (int i = 0; i < N; i++) pv[i] = 100;
    rdy_pct = 100;
    drain(2000);

    // Asynchronous reset while a byte sits in the slot.
    push_pkt(1, 8, 1'b0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (busy && uart_in_valid) found = 1;
    end
    chk("rst_setup", 32'(found), 32'(1));
    @(negedge clk_48mhz);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid",   32'(uart_in_valid), 32'(0));
    chk("arst_busy",    32'(busy),          32'(0));
    chk("arst_src_rdy", 32'(src_ready),     32'(0));
    chk("arst_grant",   32'(grant_id),      32'(N - 1));
    src_valid = '0;
    for (int i = 0; i < N; i++) q[i].delete();
    m_reset();
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    q[0] = '{8'h5A, 8'h0A};
    q[2] = '{8'h5B, 8'h0A};
    cycle();
    chk("first_grant", 32'(grant_id), 32'(0));
    drain(30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
